// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter slice.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 14;
    localparam int DMEM_DATA_W = 32;

    typedef logic [0:0] port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle of one data-memory port: request/address/data in,
// grant and tagged read return out.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arb_sel.sv
// Combinational owner selection for dmem_arbiter. Fixed priority with a
// starvation guard by default; round-robin when DMEM_ARB_RR_EN is defined.
module dmem_arb_sel
    import dmem_pkg::*;
#(
    parameter  int MAX_HOLD = 4,
    localparam int HOLD_W   = $clog2(MAX_HOLD) + 1
) (
    input  logic [1:0]        req,
    input  port_id_t          last,
    input  logic [HOLD_W-1:0] hold_cnt,
    output logic [1:0]        gnt
);

    // The non-last port as a one-hot grant vector.
    logic [1:0] other_gnt;
    assign other_gnt = (last == PORT0) ? 2'b10 : 2'b01;

`ifdef DMEM_ARB_RR_EN
    logic unused_hold;
    assign unused_hold = ^hold_cnt;

    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = other_gnt;
    end
`else
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (hold_cnt == HOLD_W'(MAX_HOLD)) ? other_gnt : 2'b01;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the load/store unit (p0) and a
// debug/DMA master (p1). DMEM_ARB_RR_EN selects round-robin arbitration.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

    port_id_t          last;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        rd_tag;
    logic [1:0]        gnt_sel;
    logic [1:0]        gnt;
    logic              any_gnt;
    port_id_t          win_port;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{p0.addr[31:ADDR_W+2], p0.addr[1:0],
                                p1.addr[31:ADDR_W+2], p1.addr[1:0]};

    dmem_arb_sel #(
        .MAX_HOLD (MAX_HOLD)
    ) u_sel (
        .req      ({p1.req, p0.req}),
        .last     (last),
        .hold_cnt (hold_cnt),
        .gnt      (gnt_sel)
    );

    // Nothing is granted while reset is held, which also keeps ram_we low.
    assign gnt      = rst_n ? gnt_sel : 2'b00;
    assign any_gnt  = |gnt;
    assign win_port = gnt[1] ? PORT1 : PORT0;

    always_comb begin
        win_we    = p0.we;
        win_addr  = p0.addr[ADDR_W+1:2];
        win_wdata = p0.wdata;
        if (gnt[1]) begin
            win_we    = p1.we;
            win_addr  = p1.addr[ADDR_W+1:2];
            win_wdata = p1.wdata;
        end
    end

    assign ram_we    = any_gnt & win_we;
    assign ram_addr  = any_gnt ? win_addr  : addr_q;
    assign ram_wdata = any_gnt ? win_wdata : wdata_q;

    always_ff @(posedge clk) begin
        if (any_gnt) begin
            addr_q  <= win_addr;
            wdata_q <= win_wdata;
        end
    end

    // Ownership and read-return tagging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last   <= PORT1;
            rd_tag <= 2'b00;
        end else begin
            rd_tag <= {gnt[1] & ~p1.we, gnt[0] & ~p0.we};
            if (any_gnt) last <= win_port;
        end
    end

`ifdef DMEM_ARB_RR_EN
    assign hold_cnt = '0;
`else
    logic other_req;
    assign other_req = (win_port == PORT0) ? p1.req : p0.req;

    // Counts consecutive wins by one port while the other one waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (!any_gnt || !other_req) begin
            hold_cnt <= '0;
        end else if (win_port != last) begin
            hold_cnt <= HOLD_W'(1);
        end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end
`endif

    assign p0.gnt    = gnt[0];
    assign p1.gnt    = gnt[1];
    assign p0.rvalid = rd_tag[0];
    assign p1.rvalid = rd_tag[1];
    assign p0.rdata  = rd_tag[0] ? ram_rdata : '0;
    assign p1.rdata  = rd_tag[1] ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural block-RAM model.
// Expected contention pattern follows DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ram_we;
    logic [13:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] mem [0:16383];

    int n_checks;
    int n_pass;

    dmem_arbiter_if #(.DATA_W(32)) p0_if ();
    dmem_arbiter_if #(.DATA_W(32)) p1_if ();

    dmem_arbiter #(
        .ADDR_W   (14),
        .DATA_W   (32),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0        (p0_if),
        .p1        (p1_if),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-before-write single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic idle_ports();
        p0_if.req = 1'b0; p0_if.we = 1'b0; p0_if.addr = '0; p0_if.wdata = '0;
        p1_if.req = 1'b0; p1_if.we = 1'b0; p1_if.addr = '0; p1_if.wdata = '0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_ports();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_ports();
        p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 32'h40; p0_if.wdata = 32'h55;
        p1_if.req = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (p0_if.gnt !== 1'b0) $display("FAIL rst_gnt0: got %b want 0", p0_if.gnt); else n_pass++;
        n_checks++; if (p1_if.gnt !== 1'b0) $display("FAIL rst_gnt1: got %b want 0", p1_if.gnt); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL rst_ram_we: got %b want 0", ram_we); else n_pass++;
        n_checks++; if ({p1_if.rvalid, p0_if.rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {p1_if.rvalid, p0_if.rvalid}); else n_pass++;
        n_checks++; if (p0_if.rdata !== 32'h0) $display("FAIL rst_rdata0: got %h want 0", p0_if.rdata); else n_pass++;
        @(negedge clk);
        idle_ports();
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 32'h0000_0010; p0_if.wdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (p0_if.gnt !== 1'b1) $display("FAIL wr_gnt0: got %b want 1", p0_if.gnt); else n_pass++;
        n_checks++; if (p1_if.gnt !== 1'b0) $display("FAIL wr_gnt1: got %b want 0", p1_if.gnt); else n_pass++;
        n_checks++; if (ram_addr !== 14'd4) $display("FAIL wr_addr: got %0d want 4", ram_addr); else n_pass++;
        n_checks++; if (ram_we !== 1'b1) $display("FAIL wr_we: got %b want 1", ram_we); else n_pass++;
        n_checks++; if (ram_wdata !== 32'hDEADBEEF) $display("FAIL wr_wdata: got %h want deadbeef", ram_wdata); else n_pass++;
        @(negedge clk);
        p0_if.we = 1'b0;
        #1;
        n_checks++; if (p0_if.gnt !== 1'b1) $display("FAIL rd_gnt0: got %b want 1", p0_if.gnt); else n_pass++;
        n_checks++; if (ram_we !== 1'b0) $display("FAIL rd_we: got %b want 0", ram_we); else n_pass++;
        n_checks++; if (p0_if.rvalid !== 1'b0) $display("FAIL wr_no_rvalid: got %b want 0", p0_if.rvalid); else n_pass++;
        @(negedge clk);
        idle_ports();
        #1;
        n_checks++; if (p0_if.rvalid !== 1'b1) $display("FAIL rd_rvalid0: got %b want 1", p0_if.rvalid); else n_pass++;
        n_checks++; if (p0_if.rdata !== 32'hDEADBEEF) $display("FAIL rd_rdata0: got %h want deadbeef", p0_if.rdata); else n_pass++;
        n_checks++; if ({p1_if.gnt, p1_if.rvalid} !== 2'b00) $display("FAIL rd_p1_quiet: got %b want 00", {p1_if.gnt, p1_if.rvalid}); else n_pass++;
        n_checks++; if (p1_if.rdata !== 32'h0) $display("FAIL rd_p1_rdata: got %h want 0", p1_if.rdata); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (p0_if.rvalid !== 1'b0) $display("FAIL rd_pulse_end: got %b want 0", p0_if.rvalid); else n_pass++;
        n_checks++; if (p0_if.rdata !== 32'h0) $display("FAIL rd_rdata_idle: got %h want 0", p0_if.rdata); else n_pass++;
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [10];
`ifdef DMEM_ARB_RR_EN
        for (int i = 0; i < 10; i++) exp_g[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
        for (int i = 0; i < 10; i++) exp_g[i] = (i % 5 == 4) ? 2'b10 : 2'b01;
`endif
        apply_reset();
        @(negedge clk);
        p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 32'd5 << 2;
        p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 32'd9 << 2;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_checks++;
            if ({p1_if.gnt, p0_if.gnt} !== exp_g[c])
                $display("FAIL cont_gnt[%0d]: got %b want %b", c, {p1_if.gnt, p0_if.gnt}, exp_g[c]);
            else n_pass++;
            n_checks++;
            if (ram_addr !== (exp_g[c][1] ? 14'd9 : 14'd5))
                $display("FAIL cont_addr[%0d]: got %0d want %0d", c, ram_addr, exp_g[c][1] ? 9 : 5);
            else n_pass++;
            if (c > 0) begin
                n_checks++;
                if ({p1_if.rvalid, p0_if.rvalid} !== exp_g[c-1])
                    $display("FAIL cont_rvalid[%0d]: got %b want %b", c, {p1_if.rvalid, p0_if.rvalid}, exp_g[c-1]);
                else n_pass++;
            end
            @(negedge clk);
        end
        idle_ports();
        #1;
        n_checks++;
        if ({p1_if.rvalid, p0_if.rvalid} !== exp_g[9])
            $display("FAIL cont_rvalid_last: got %b want %b", {p1_if.rvalid, p0_if.rvalid}, exp_g[9]);
        else n_pass++;
    endtask

    task automatic test_same_word();
        @(negedge clk);
        p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 32'd7 << 2;
        p1_if.req = 1'b1; p1_if.we = 1'b1; p1_if.addr = 32'd7 << 2; p1_if.wdata = 32'h1234;
        #1;
        n_checks++; if ({p1_if.gnt, p0_if.gnt} !== 2'b01) $display("FAIL sw_one_gnt: got %b want 01", {p1_if.gnt, p0_if.gnt}); else n_pass++;
        @(negedge clk);
        p0_if.req = 1'b0;
        #1;
        n_checks++; if ({p1_if.gnt, p0_if.gnt} !== 2'b10) $display("FAIL sw_p1_gnt: got %b want 10", {p1_if.gnt, p0_if.gnt}); else n_pass++;
        n_checks++; if (ram_we !== 1'b1) $display("FAIL sw_we: got %b want 1", ram_we); else n_pass++;
        n_checks++; if (p0_if.rvalid !== 1'b1) $display("FAIL sw_rvalid0: got %b want 1", p0_if.rvalid); else n_pass++;
        n_checks++; if (p0_if.rdata !== 32'h0) $display("FAIL sw_old_data: got %h want 0", p0_if.rdata); else n_pass++;
        @(negedge clk);
        p1_if.req = 1'b0; p1_if.we = 1'b0;
        p0_if.req = 1'b1;
        #1;
        n_checks++; if (p0_if.gnt !== 1'b1) $display("FAIL sw_reread_gnt: got %b want 1", p0_if.gnt); else n_pass++;
        n_checks++; if (p1_if.rvalid !== 1'b0) $display("FAIL sw_no_wr_rvalid: got %b want 0", p1_if.rvalid); else n_pass++;
        @(negedge clk);
        idle_ports();
        #1;
        n_checks++; if (p0_if.rdata !== 32'h1234) $display("FAIL sw_new_data: got %h want 1234", p0_if.rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h3333_0003;
        for (int w = 1; w <= 3; w++) begin
            @(negedge clk);
            p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 32'(w) << 2; p0_if.wdata = vals[w-1];
            #1;
            n_checks++; if (ram_we !== 1'b1 || p0_if.gnt !== 1'b1) $display("FAIL b2b_wr[%0d]: got we=%b gnt=%b want 1/1", w, ram_we, p0_if.gnt); else n_pass++;
        end
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            if (r <= 3) begin
                p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 32'(r) << 2;
            end else begin
                idle_ports();
            end
            #1;
            if (r <= 3) begin
                n_checks++; if (p0_if.gnt !== 1'b1 || ram_addr !== 14'(r)) $display("FAIL b2b_rd_gnt[%0d]: got gnt=%b addr=%0d want 1/%0d", r, p0_if.gnt, ram_addr, r); else n_pass++;
            end
            if (r >= 2) begin
                n_checks++; if (p0_if.rvalid !== 1'b1 || p0_if.rdata !== vals[r-2]) $display("FAIL b2b_rdata[%0d]: got v=%b %h want 1 %h", r-1, p0_if.rvalid, p0_if.rdata, vals[r-2]); else n_pass++;
            end
        end
        @(negedge clk); #1;
        n_checks++; if ({p1_if.rvalid, p0_if.rvalid} !== 2'b00) $display("FAIL b2b_tail: got %b want 00", {p1_if.rvalid, p0_if.rvalid}); else n_pass++;
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 32'd2 << 2;
        #1;
        n_checks++; if (p1_if.gnt !== 1'b1) $display("FAIL rip_gnt1: got %b want 1", p1_if.gnt); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_ports();
        p0_if.req = 1'b1; p0_if.we = 1'b1; p0_if.addr = 32'h40; p0_if.wdata = 32'hBAD;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            n_checks++; if (p1_if.rvalid !== 1'b0) $display("FAIL rip_rvalid1[%0d]: got %b want 0", k, p1_if.rvalid); else n_pass++;
            n_checks++; if (ram_we !== 1'b0) $display("FAIL rip_we[%0d]: got %b want 0", k, ram_we); else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_ports();
        #1;
        n_checks++; if (p1_if.rvalid !== 1'b0) $display("FAIL rip_post_rvalid1: got %b want 0", p1_if.rvalid); else n_pass++;
        @(negedge clk);
        p0_if.req = 1'b1; p0_if.we = 1'b0; p0_if.addr = 32'd1 << 2;
        p1_if.req = 1'b1; p1_if.we = 1'b0; p1_if.addr = 32'd2 << 2;
        #1;
        n_checks++; if ({p1_if.gnt, p0_if.gnt} !== 2'b01) $display("FAIL rip_first_gnt: got %b want 01", {p1_if.gnt, p0_if.gnt}); else n_pass++;
        @(negedge clk);
        idle_ports();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        test_reset();
        test_write_read();
        test_contention();
        test_same_word();
        test_back_to_back();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data RAM between the pipeline load/store unit (port 0) and a debug/DMA master (port 1). Each cycle it selects at most one requester, drives the RAM word address, write enable and write data, and returns read data to the owning port one cycle later with a valid strobe. It sits between the MEM stage / debug master and the block-RAM instance, replacing the direct pipeline-to-RAM connection.

## Interface
- ADDR_W, 14, RAM word-address width (RAM depth = 2^ADDR_W words)
- DATA_W, 32, data width
- MAX_HOLD, 4, maximum consecutive grants to one port while the other port is requesting (fixed-priority mode only)

Ports (port p is 0 or 1):
- clk  in  1  clock; all state and the RAM update on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- pN_req  in  1  access request, held until granted
- pN_we  in  1  1 = write, 0 = read
- pN_addr  in  32  byte address; word index is addr[ADDR_W+1:2]; addr[1:0] ignored
- pN_wdata  in  DATA_W  write data
- pN_gnt  out  1  request accepted this cycle
- pN_rvalid  out  1  read data valid (one cycle after a read grant)
- pN_rdata  out  DATA_W  read data; 0 when pN_rvalid = 0
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after the address

## Operation
- Owner selection is combinational from the current requests and registered state. At most one gnt is high per cycle. gnt = 0 when req = 0.
- Granted port: ram_addr = pN_addr[ADDR_W+1:2] and ram_we = pN_we & gnt. ram_wdata = pN_wdata.
- No grant: ram_we = 0, and ram_addr/ram_wdata hold their previous values. The idle address is don't-care to the bench.
- Read tag: a 2-bit one-hot register rd_tag is set from {p1 read grant, p0 read grant}. The next cycle, pN_rvalid = rd_tag[N] and pN_rdata = ram_rdata when rd_tag[N] = 1.
- Registered state:
  - last: last granted port; reset value 1, so port 0 wins first.
  - hold_cnt: consecutive grants to `last` while the other port requests; width $clog2(MAX_HOLD)+1.
- Fixed-priority selection (default):
  - Port 0 wins over port 1.
  - If hold_cnt == MAX_HOLD and the other port is requesting, the other port wins.
  - hold_cnt increments on a grant to `last` while the other port requests. It resets to 1 on an owner change and to 0 when the other port is not requesting.
- Requester rules:
  - pN_we, pN_addr and pN_wdata must stay stable while pN_req = 1 and gnt = 0.
  - After gnt, the requester may present a new request in the next cycle. Back-to-back reads and writes are served at one per cycle.
- Reset (asynchronous):
  - gnt, ram_we, rvalid, rd_tag and hold_cnt go to 0 and last goes to 1.
  - An in-flight read is dropped: no rvalid after reset release.
  - ram_we is forced to 0 while rst_n = 0.

## Timing
- Grant latency: 0 cycles when uncontested.
- Writes commit at the rising edge that ends the grant cycle.
- Read latency: rvalid and rdata appear exactly 1 cycle after gnt, for one cycle.
- Throughput: 1 access per cycle total.
- Simultaneous requests: exactly one gnt. The loser keeps req high and is granted in a later cycle.
- Worst-case wait for port 1 in fixed-priority mode is MAX_HOLD cycles. In round-robin mode it is 1 cycle.
- A read followed by a write to the same word in the next cycle returns the old data.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin selection.
  - When both ports request, the port ≠ last wins. A single requester always wins.
  - hold_cnt and MAX_HOLD are unused, and the counter is not synthesised.
- DMEM_ARB_RR_EN undefined: fixed priority to port 0 with the MAX_HOLD starvation guard described above.

## Structure
- Shared package dmem_pkg:
  - DMEM_ADDR_W and DMEM_DATA_W constants.
  - Port-index typedef port_id_t (1 bit).
- No sub-module is needed for a single module. Optionally factor the selector into dmem_arb_sel: inputs are the two reqs, last and hold_cnt; output is the one-hot grant.

## Test plan
- Reset release, p0 writes 0xDEADBEEF to 0x0000_0010, then reads it: p0_gnt the same cycle, ram_addr = 4, and p0_rvalid with 0xDEADBEEF one cycle after the read grant. p1 outputs stay 0.
- p0 and p1 both read continuously (fixed priority, MAX_HOLD = 4): p0 granted 4 cycles, then p1 for 1 cycle, repeating. The rvalid tags match the grant owner.
- Same stimulus with DMEM_ARB_RR_EN defined: grants alternate p0, p1, p0, … starting with p0.
- p1 writes 0x1234 to word 7 while p0 reads word 7 in the same cycle: exactly one gnt. The read returns 0x1234 only if the write was granted first.
- Back-to-back p0 reads of words 1, 2, 3 with no p1 traffic: 3 grants in 3 cycles, and rvalid on 3 consecutive cycles in order.
- rst_n asserted in the cycle after a p1 read grant: p1_rvalid never pulses, ram_we = 0 during reset, and the first post-reset grant goes to p0.
